// File: rtl/rptr_empty_level_pkg.sv
// ---------------------------------------------------------------------------
// rptr_empty_level_pkg
//
// Purpose : Pointer helpers shared by both sides of an asynchronous FIFO.
//           The read side (rptr_empty_level) and the write side use the same
//           Gray/binary conversions, so they live here in one place.
//
// Contents:
//   PTR_FN_W  - width of the helper function arguments (upper bits zero)
//   bin2gray  - binary to reflected Gray code
//   gray2bin  - reflected Gray code to binary (XOR prefix from the MSB)
//
// Callers zero-extend their pointer to PTR_FN_W bits, call the helper and
// size-cast the result back to their pointer width.  Conversions of
// zero-extended values are exact, because leading zeros map to zeros in
// both directions.
// ---------------------------------------------------------------------------
package rptr_empty_level_pkg;

    localparam int PTR_FN_W = 32;

    // Binary to Gray: each Gray bit is the XOR of adjacent binary bits.
    function automatic logic [PTR_FN_W-1:0] bin2gray(input logic [PTR_FN_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: each binary bit is the XOR of all Gray bits at and
    // above it, computed as a running prefix starting at the MSB.
    function automatic logic [PTR_FN_W-1:0] gray2bin(input logic [PTR_FN_W-1:0] g);
        logic [PTR_FN_W-1:0] b;
        b[PTR_FN_W-1] = g[PTR_FN_W-1];
        for (int i = PTR_FN_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/rptr_empty_level_gray2bin.sv
// ---------------------------------------------------------------------------
// gray2bin
//
// Purpose : Purely combinational Gray-to-binary converter of any width.
//           Binary bit i is the XOR of Gray bits WIDTH-1 down to i, built as
//           a ripple prefix from the MSB.
//
// Parameters:
//   WIDTH   - code width in bits (>= 1)
//
// Ports:
//   i_gray  - Gray-coded input
//   o_bin   - binary equivalent of i_gray
// ---------------------------------------------------------------------------
module gray2bin
    import rptr_empty_level_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    // The MSB passes straight through; every lower bit folds in the
    // already-converted bit above it.
    assign o_bin[WIDTH-1] = i_gray[WIDTH-1];

    for (genvar g_i = WIDTH - 2; g_i >= 0; g_i--) begin : g_prefix
        assign o_bin[g_i] = o_bin[g_i+1] ^ i_gray[g_i];
    end

endmodule

// File: rtl/rptr_empty_level.sv
// ---------------------------------------------------------------------------
// rptr_empty_level
//
// Purpose : Read-side pointer and status logic of an asynchronous FIFO.
//           It keeps the binary and Gray read pointers, drives the memory
//           read address and derives empty, fill level, almost-empty and
//           underflow from the write pointer that has already been
//           synchronised into rclk.
//
// Parameters:
//   ADDRSIZE     - memory address width; FIFO depth is 2**ADDRSIZE
//   AEMPTY_LEVEL - almost-empty threshold in entries (0 .. 2**ADDRSIZE)
//
// Ports:
//   rclk       in   read-domain clock (only clock)
//   rrst       in   synchronous active-high reset
//   rinc       in   pop request from the consumer
//   rq2_wptr   in   Gray write pointer, 2-flop synchronised into rclk
//   rempty     out  FIFO empty (registered)
//   raddr      out  binary memory read address
//   rptr       out  registered Gray read pointer for the write domain
//   rlevel     out  registered fill count, 0 .. 2**ADDRSIZE
//   raempty    out  registered almost-empty flag (rlevel <= AEMPTY_LEVEL)
//   runderflow out  registered one-cycle pulse for a pop while empty
//
// Handshake: rinc acts as a "valid" from the consumer and ~rempty as the
// "ready" of this block.  A pop is accepted on an rclk edge exactly when
// rinc = 1 and the registered rempty = 0 at that edge; raddr then advances
// on that same edge.  rinc = 1 with rempty = 1 is refused, leaves the
// pointers untouched and produces a runderflow pulse one cycle later.
// ---------------------------------------------------------------------------
module rptr_empty_level
    import rptr_empty_level_pkg::*;
#(
    parameter int ADDRSIZE     = 4,
    parameter int AEMPTY_LEVEL = 1
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    output logic                rempty,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE:0]   rlevel,
    output logic                raempty,
    output logic                runderflow
);

    // Pointers carry one extra wrap bit so full and empty are distinct.
    localparam int              PTR_W  = ADDRSIZE + 1;
    localparam logic [PTR_W-1:0] AE_LVL = PTR_W'(AEMPTY_LEVEL);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] r_bin;
    logic [PTR_W-1:0] r_gray;
    logic [PTR_W-1:0] r_level;
    logic             r_empty;
    logic             r_aempty;
    logic             r_underflow;

    // ------------------------------------------------------------------
    // Next-state terms
    // ------------------------------------------------------------------
    logic             w_pop;
    logic [PTR_W-1:0] w_bin_next;
    logic [PTR_W-1:0] w_gray_next;
    logic [PTR_W-1:0] w_wbin;
    logic [PTR_W-1:0] w_level_next;
    logic             w_empty_next;
    logic             w_aempty_next;
    logic             w_underflow_next;

    // A pop is only honoured against the registered empty flag, so a write
    // pointer arriving in the same cycle cannot make an empty pop legal.
    assign w_pop       = rinc & ~r_empty;
    assign w_bin_next  = r_bin + PTR_W'(w_pop);
    assign w_gray_next = PTR_W'(bin2gray(PTR_FN_W'(w_bin_next)));

    gray2bin #(
        .WIDTH (PTR_W)
    ) u_wptr_gray2bin (
        .i_gray (rq2_wptr),
        .o_bin  (w_wbin)
    );

    // Modulo subtraction over the wrap-extended pointers gives the fill
    // count directly, including across the 2**PTR_W wrap.
    assign w_level_next     = w_wbin - w_bin_next;

    // Comparing Gray codes is equivalent to comparing binaries, so empty
    // coincides with a zero level in every cycle.
    assign w_empty_next     = (w_gray_next == rq2_wptr);
    assign w_aempty_next    = (w_level_next <= AE_LVL);
    assign w_underflow_next = rinc & r_empty;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_bin       <= '0;
            r_gray      <= '0;
            r_level     <= '0;
            r_empty     <= 1'b1;
            r_aempty    <= 1'b1;
            r_underflow <= 1'b0;
        end else begin
            r_bin       <= w_bin_next;
            r_gray      <= w_gray_next;
            r_level     <= w_level_next;
            r_empty     <= w_empty_next;
            r_aempty    <= w_aempty_next;
            r_underflow <= w_underflow_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign raddr      = r_bin[ADDRSIZE-1:0];
    assign rptr       = r_gray;
    assign rlevel     = r_level;
    assign rempty     = r_empty;
    assign raempty    = r_aempty;
    assign runderflow = r_underflow;

endmodule

// File: tb/tb_rptr_empty_level.sv
// ---------------------------------------------------------------------------
// tb_rptr_empty_level
//
// Read-side pointer block with ADDRSIZE=4, AEMPTY_LEVEL=1.  The reference
// model tracks the number of entries written and read as plain integers
// (mod 32); every expected output follows from those two counts.
// ---------------------------------------------------------------------------
module tb_rptr_empty_level;

    localparam int ADDRSIZE     = 4;
    localparam int AEMPTY_LEVEL = 1;
    localparam int DEPTH        = 1 << ADDRSIZE;
    localparam int PTR_MOD      = 2 * DEPTH;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic       rclk = 1'b0;
    logic       rrst = 1'b1;
    logic       rinc = 1'b0;
    logic [4:0] rq2_wptr = '0;
    logic       rempty;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic [4:0] rlevel;
    logic       raempty;
    logic       runderflow;

    always #5 rclk = ~rclk;

    rptr_empty_level #(
        .ADDRSIZE     (ADDRSIZE),
        .AEMPTY_LEVEL (AEMPTY_LEVEL)
    ) dut (
        .rclk       (rclk),
        .rrst       (rrst),
        .rinc       (rinc),
        .rq2_wptr   (rq2_wptr),
        .rempty     (rempty),
        .raddr      (raddr),
        .rptr       (rptr),
        .rlevel     (rlevel),
        .raempty    (raempty),
        .runderflow (runderflow)
    );

    // ------------------------------------------------------------------
    // Reference model: write count m_w and read count m_r, both mod 32.
    // ------------------------------------------------------------------
    int  m_w     = 0;
    int  m_r     = 0;
    bit  m_empty = 1'b1;

    int  checks   = 0;
    int  failures = 0;

    // Expected vector: {empty, raddr[3:0], rptr[4:0], level[4:0], aempty, underflow}
    logic [16:0] exp_q[$];

    function automatic logic [4:0] to_gray(input int v);
        logic [4:0] b;
        b = 5'(v % PTR_MOD);
        return b ^ (b >> 1);
    endfunction

    // ------------------------------------------------------------------
    // Driver: inputs change 1 time unit after the falling edge; the
    // expected result of the following rising edge is queued at once.
    // ------------------------------------------------------------------
    task automatic step(input bit rst, input bit inc, input int w_target);
        bit prev_empty;
        int lvl;
        bit e_aempty;
        bit e_unf;
        @(negedge rclk);
        #1;
        rrst     = rst;
        rinc     = inc;
        rq2_wptr = to_gray(w_target);

        prev_empty = m_empty;
        m_w = ((w_target % PTR_MOD) + PTR_MOD) % PTR_MOD;
        if (rst) begin
            m_r      = 0;
            lvl      = 0;
            m_empty  = 1'b1;
            e_aempty = 1'b1;
            e_unf    = 1'b0;
        end else begin
            if (inc && !prev_empty) m_r = (m_r + 1) % PTR_MOD;
            lvl      = (m_w - m_r + PTR_MOD) % PTR_MOD;
            m_empty  = (lvl == 0);
            e_aempty = (lvl <= AEMPTY_LEVEL);
            e_unf    = inc && prev_empty;
        end
        exp_q.push_back({m_empty, 4'(m_r % DEPTH), to_gray(m_r), 5'(lvl),
                         e_aempty, e_unf});
    endtask

    function automatic int model_level();
        return (m_w - m_r + PTR_MOD) % PTR_MOD;
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard monitor: outputs sampled 1 time unit after each rising edge
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [16:0] e;
        forever begin
            @(posedge rclk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rempty",     5'(rempty),     5'(e[16]));
                chk("raddr",      5'(raddr),      5'(e[15:12]));
                chk("rptr",       rptr,           e[11:7]);
                chk("rlevel",     rlevel,         e[6:2]);
                chk("raempty",    5'(raempty),    5'(e[1]));
                chk("runderflow", 5'(runderflow), 5'(e[0]));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        // Reset held for a few cycles; outputs must sit at reset values.
        repeat (3) step(1'b1, 1'b0, 0);

        // Three entries appear, then three pops drain them.
        step(1'b0, 1'b0, 3);
        repeat (3) step(1'b0, 1'b1, 3);
        step(1'b0, 1'b0, 3);

        // Pops while empty: refused, underflow pulses, then clears.
        repeat (4) step(1'b0, 1'b1, 3);
        repeat (2) step(1'b0, 1'b0, 3);

        // Write pointer 16 ahead, 32 simultaneous pop+write cycles across
        // the pointer wrap.
        step(1'b1, 1'b0, 0);
        step(1'b0, 1'b0, 16);
        for (int i = 0; i < 32; i++) step(1'b0, 1'b1, m_w + 1);
        repeat (2) step(1'b0, 1'b0, m_w);

        // Drain to one entry, then pop and write in the same cycle.
        for (int i = 0; i < DEPTH && model_level() > 1; i++)
            step(1'b0, 1'b1, m_w);
        step(1'b0, 1'b1, m_w + 1);
        step(1'b0, 1'b0, m_w);

        // Level 5, then a one-cycle reset while popping, then resume.
        step(1'b0, 1'b0, m_r + 5);
        step(1'b1, 1'b1, 5);
        repeat (4) step(1'b0, 1'b1, 5);
        step(1'b0, 1'b0, 5);

        // Empty-pop coinciding with a write-pointer advance.
        repeat (2) step(1'b0, 1'b1, m_w);
        step(1'b0, 1'b1, m_w + 2);
        step(1'b0, 1'b0, m_w);

        // Randomised traffic, keeping the write pointer within one depth.
        for (int i = 0; i < 600; i++) begin
            bit rst;
            bit inc;
            int r_after;
            int room;
            int w_new;
            rst = ($urandom_range(0, 63) == 0);
            inc = ($urandom_range(0, 2) != 0);
            if (rst) begin
                w_new = $urandom_range(0, DEPTH);
            end else begin
                r_after = (inc && !m_empty) ? (m_r + 1) % PTR_MOD : m_r;
                room    = DEPTH - ((m_w - r_after + PTR_MOD) % PTR_MOD);
                w_new   = m_w + $urandom_range(0, (room > 3) ? 3 : room);
            end
            step(rst, inc, w_new);
        end
        step(1'b0, 1'b0, m_w);

        // Let the monitor consume every queued expectation, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge rclk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
